data_memory_responder: RTL and testbench

- Data-memory responder on the processor's load/store port: accepts one request at a time, performs the RV32I byte, halfword or word access, and returns a response.
- The processor's memory stage is the initiator and this block is the target.
- Word-organised internal RAM; both sides use a valid/ready handshake.
- Configurable wait-state latency, so the pipeline stall logic can be exercised.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lane_align.sv | 99 +++++++++
 rtl/data_memory_responder.sv | 164 ++++++++++++++++
 tb/tb_data_memory_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I funct3 width
// codes, the responder FSM state type and the byte-lane enable type.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef logic [3:0] dmem_be_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for RV32I loads and stores.
// Store path: width code and low address bits -> lane enables and
// replicated write data. Load path: raw RAM word -> extended result.
// Error path: illegal width code; with DMEM_MISALIGN_CHECK_EN defined,
// misaligned half/word accesses are also flagged. Any error suppresses
// both the lane enables and the load result.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        write,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output dmem_be_t    be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        error
);

    logic        illegal_s;
    logic        misalign_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Classify the access: unknown width codes, plus misalignment when enabled.
    always_comb begin
        illegal_s  = 1'b1;
        misalign_s = 1'b0;
        if (write) begin
            case (funct3)
                F3_B, F3_H, F3_W: illegal_s = 1'b0;
                default:          illegal_s = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: illegal_s = 1'b0;
                default:                        illegal_s = 1'b1;
            endcase
        end
`ifdef DMEM_MISALIGN_CHECK_EN
        case (funct3)
            F3_H, F3_HU: misalign_s = addr_lo[0];
            F3_W:        misalign_s = (addr_lo != 2'b00);
            default:     misalign_s = 1'b0;
        endcase
`endif
        error = illegal_s | misalign_s;
    end

    // Store steering: data is replicated across lanes, enables pick the target.
    always_comb begin
        be         = 4'b0000;
        wdata_lane = 32'h0000_0000;
        if (write && !error) begin
            case (funct3)
                F3_B: begin
                    be         = 4'b0001 << addr_lo;
                    wdata_lane = {4{wdata[7:0]}};
                end
                F3_H: begin
                    be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_lane = {2{wdata[15:0]}};
                end
                F3_W: begin
                    be         = 4'b1111;
                    wdata_lane = wdata;
                end
                default: begin
                    be         = 4'b0000;
                    wdata_lane = 32'h0000_0000;
                end
            endcase
        end else begin
            be         = 4'b0000;
            wdata_lane = 32'h0000_0000;
        end
    end

    // Load extraction: select the addressed byte/half and sign- or zero-extend.
    always_comb begin
        byte_s    = rword[{addr_lo, 3'b000} +: 8];
        half_s    = addr_lo[1] ? rword[31:16] : rword[15:0];
        rdata_ext = 32'h0000_0000;
        if (!write && !error) begin
            case (funct3)
                F3_B:    rdata_ext = {{24{byte_s[7]}}, byte_s};
                F3_H:    rdata_ext = {{16{half_s[15]}}, half_s};
                F3_W:    rdata_ext = rword;
                F3_BU:   rdata_ext = {24'h00_0000, byte_s};
                F3_HU:   rdata_ext = {16'h0000, half_s};
                default: rdata_ext = 32'h0000_0000;
            endcase
        end else begin
            rdata_ext = 32'h0000_0000;
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// RV32I data-memory responder: one outstanding request, LATENCY wait
// states, word-organised RAM with little-endian byte lanes.
// Optional macro DMEM_MISALIGN_CHECK_EN (see dmem_lane_align) rejects
// misaligned half/word accesses instead of dropping low address bits.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam int         AW        = IDX_W + 2;
    localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    dmem_state_t state_r;
    logic [3:0]  count_r;
    logic        write_r;
    logic [2:0]  funct3_r;
    logic [AW-1:0] addr_r;
    logic [31:0] wdata_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_error_r;
    logic [31:0] mem_r [DEPTH_WORDS];

    logic          accept_s;
    logic          commit_s;
    logic          sel_write_s;
    logic [2:0]    sel_funct3_s;
    logic [AW-1:0] sel_addr_s;
    logic [31:0]   sel_wdata_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]   rword_s;
    dmem_be_t      be_s;
    logic [31:0]   wlane_s;
    logic [31:0]   rdata_ext_s;
    logic          error_s;
    logic          addr_hi_unused_s;

    assign req_ready        = (state_r == IDLE);
    assign accept_s         = req_valid && req_ready;
    assign rsp_valid        = rsp_valid_r;
    assign rsp_rdata        = rsp_rdata_r;
    assign rsp_error        = rsp_error_r;
    assign addr_hi_unused_s = ^req_addr[31:AW];
    assign rword_s          = mem_r[idx_s];

    // Live request feeds the datapath in IDLE (a zero-latency commit happens on
    // the accept edge); afterwards the latched copy is used. Also flags the commit edge.
    always_comb begin
        if (state_r == IDLE) begin
            sel_write_s  = req_write;
            sel_funct3_s = req_funct3;
            sel_addr_s   = req_addr[AW-1:0];
            sel_wdata_s  = req_wdata;
        end else begin
            sel_write_s  = write_r;
            sel_funct3_s = funct3_r;
            sel_addr_s   = addr_r;
            sel_wdata_s  = wdata_r;
        end
        idx_s    = sel_addr_s[AW-1:2];
        commit_s = 1'b0;
        case (state_r)
            IDLE:    commit_s = accept_s && (LATENCY == 32'sd0);
            WAIT:    commit_s = (count_r == 4'd0);
            RESP:    commit_s = 1'b0;
            default: commit_s = 1'b0;
        endcase
    end

    dmem_lane_align u_align (
        .write      (sel_write_s),
        .funct3     (sel_funct3_s),
        .addr_lo    (sel_addr_s[1:0]),
        .wdata      (sel_wdata_s),
        .rword      (rword_s),
        .be         (be_s),
        .wdata_lane (wlane_s),
        .rdata_ext  (rdata_ext_s),
        .error      (error_s)
    );

    // Byte-lane RAM write on the edge entering RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit_s && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wlane_s[8*b +: 8];
                end
            end
        end
    end

    // Control FSM: request latch, wait counter and registered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            count_r     <= 4'd0;
            write_r     <= 1'b0;
            funct3_r    <= 3'b000;
            addr_r      <= '0;
            wdata_r     <= 32'h0000_0000;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_error_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        write_r  <= req_write;
                        funct3_r <= req_funct3;
                        addr_r   <= req_addr[AW-1:0];
                        wdata_r  <= req_wdata;
                        if (LATENCY == 32'sd0) begin
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_rdata_r <= rdata_ext_s;
                            rsp_error_r <= error_s;
                        end else begin
                            state_r <= WAIT;
                            count_r <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (count_r == 4'd0) begin
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= rdata_ext_s;
                        rsp_error_r <= error_s;
                    end else begin
                        count_r <= count_r - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_r     <= IDLE;
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder (DEPTH_WORDS=1024, LATENCY=2).
// Expected results come from a byte-level reference model of RV32I loads/stores.
module tb_data_memory_responder;

    localparam int DEPTH_WORDS = 1024;
    localparam int LATENCY     = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem_m [DEPTH_WORDS];

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error)
    );

    // Reference model: applies a store to mem_m or computes a load result.
    task automatic model_access(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int idx, off, size, start;
        bit legal, mis;
        logic [31:0] word, val, mask;
        idx   = int'(addr[11:2]);
        off   = int'(addr[1:0]);
        legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis   = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        mis = (off % size) != 0;
`endif
        er = !legal || mis;
        rd = 32'h0;
        if (!er) begin
            start = (size == 4) ? 0 : (size == 2) ? (off & 2) : off;
            if (w) begin
                word = mem_m[idx];
                for (int k = 0; k < size; k++) word[8*(start+k) +: 8] = wd[8*k +: 8];
                mem_m[idx] = word;
            end else begin
                val  = mem_m[idx] >> (8 * start);
                mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
                rd   = val & mask;
                if (!f3[2] && size < 4 && val[8*size-1]) rd = rd | ~mask;
            end
        end
    endtask

    // One complete request/response with latency, data and handshake checks.
    task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input string name,
                       output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          cyc;
        model_access(w, f3, addr, wd, exp_rd, exp_er);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s idle_ready got=%b exp=1", name, req_ready);
        end
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); cyc = 1; #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        while (rsp_valid !== 1'b1 && cyc < 64) begin
            @(posedge clk); cyc++; #1;
        end
        checks++;
        if (cyc != LATENCY + 1 || rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=%0d", name, cyc, LATENCY + 1);
        end
        rd = rsp_rdata; er = rsp_error;
        checks++;
        if (rsp_rdata !== exp_rd) begin
            failures++;
            $display("FAIL %s rdata got=%h exp=%h", name, rsp_rdata, exp_rd);
        end
        checks++;
        if (rsp_error !== exp_er) begin
            failures++;
            $display("FAIL %s error got=%b exp=%b", name, rsp_error, exp_er);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s release got valid=%b ready=%b exp 0/1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state got v=%b d=%h e=%b r=%b exp 0/0/0/1",
                     rsp_valid, rsp_rdata, rsp_error, req_ready);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er;
        txn(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, "sw_10", rd, er);
        txn(1'b0, 3'b010, 32'h10, 32'h0, "lw_10", rd, er);
        checks++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            failures++;
            $display("FAIL lw_10_const got=%h/%b exp=deadbeef/0", rd, er);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic er;
        txn(1'b1, 3'b000, 32'h13, 32'h0000_0080, "sb_13", rd, er);
        txn(1'b0, 3'b000, 32'h13, 32'h0, "lb_13", rd, er);
        checks++;
        if (rd !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_13_const got=%h exp=ffffff80", rd); end
        txn(1'b0, 3'b100, 32'h13, 32'h0, "lbu_13", rd, er);
        checks++;
        if (rd !== 32'h0000_0080) begin failures++; $display("FAIL lbu_13_const got=%h exp=00000080", rd); end
        txn(1'b0, 3'b010, 32'h10, 32'h0, "lw_10_after_sb", rd, er);
        checks++;
        if (rd !== 32'h80AD_BEEF) begin failures++; $display("FAIL lw_sb_const got=%h exp=80adbeef", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic er;
        txn(1'b1, 3'b010, 32'h20, 32'h5566_7788, "sw_20", rd, er);
        txn(1'b1, 3'b001, 32'h22, 32'h1234_ABCD, "sh_22", rd, er);
        txn(1'b0, 3'b101, 32'h22, 32'h0, "lhu_22", rd, er);
        checks++;
        if (rd !== 32'h0000_ABCD) begin failures++; $display("FAIL lhu_22_const got=%h exp=0000abcd", rd); end
        txn(1'b0, 3'b001, 32'h22, 32'h0, "lh_22", rd, er);
        checks++;
        if (rd !== 32'hFFFF_ABCD) begin failures++; $display("FAIL lh_22_const got=%h exp=ffffabcd", rd); end
        txn(1'b0, 3'b010, 32'h20, 32'h0, "lw_20", rd, er);
        checks++;
        if (rd !== 32'hABCD_7788) begin failures++; $display("FAIL lw_20_const got=%h exp=abcd7788", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er;
        txn(1'b0, 3'b011, 32'h10, 32'h0, "load_f3_011", rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin failures++; $display("FAIL ld011_const got=%h/%b exp=0/1", rd, er); end
        txn(1'b1, 3'b111, 32'h10, 32'h1111_2222, "store_f3_111", rd, er);
        checks++;
        if (er !== 1'b1) begin failures++; $display("FAIL st111_const got=%b exp=1", er); end
        txn(1'b0, 3'b010, 32'h10, 32'h0, "lw_10_after_err", rd, er);
        checks++;
        if (rd !== 32'h80AD_BEEF) begin failures++; $display("FAIL lw_err_const got=%h exp=80adbeef", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_rd; logic exp_er; int cyc;
        model_access(1'b0, 3'b010, 32'h20, 32'h0, exp_rd, exp_er);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
        @(posedge clk); cyc = 1; #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h24; req_wdata = 32'h0BAD_0BAD;
        while (rsp_valid !== 1'b1 && cyc < 64) begin @(posedge clk); cyc++; #1; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || rsp_error !== exp_er || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_%0d got v=%b d=%h r=%b exp 1/%h/0", i, rsp_valid, rsp_rdata, req_ready, exp_rd);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL no_accept_on_release got v=%b r=%b exp 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic er;
        txn(1'b1, 3'b010, 32'h30, 32'h1357_9BDF, "sw_30_init", rd, er);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_wait got v=%b d=%h e=%b r=%b exp 0/0/0/1",
                     rsp_valid, rsp_rdata, rsp_error, req_ready);
        end
        @(negedge clk); @(negedge clk); reset = 1'b0;
        txn(1'b0, 3'b010, 32'h30, 32'h0, "lw_30_after_reset", rd, er);
        checks++;
        if (rd !== 32'h1357_9BDF) begin failures++; $display("FAIL dropped_write got=%h exp=13579bdf", rd); end
    endtask

    task automatic test_misalign_alias();
        logic [31:0] rd; logic er;
        txn(1'b0, 3'b010, 32'h11, 32'h0, "lw_11", rd, er);
        checks++;
`ifdef DMEM_MISALIGN_CHECK_EN
        if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL lw_11_const got=%h/%b exp=0/1", rd, er); end
`else
        if (er !== 1'b0 || rd !== 32'h80AD_BEEF) begin failures++; $display("FAIL lw_11_const got=%h/%b exp=80adbeef/0", rd, er); end
`endif
        txn(1'b1, 3'b010, 32'h1010, 32'h0BAD_CAFE, "sw_1010", rd, er);
        txn(1'b0, 3'b010, 32'h10, 32'h0, "lw_10_alias", rd, er);
        checks++;
        if (rd !== 32'h0BAD_CAFE) begin failures++; $display("FAIL alias_const got=%h exp=0badcafe", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr; logic er;
        for (int i = 0; i < 16; i++) txn(1'b1, 3'b010, 32'(i * 4), $urandom, "rnd_init", rd, er);
        for (int i = 0; i < 250; i++) begin
            addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            txn(1'($urandom), 3'($urandom), addr, $urandom, "rnd", rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_mid_wait();
        test_misalign_alias();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
